// File: rtl/uart_rx_ctrl.sv
// UART receive controller: FWFT byte FIFO with overrun flag and idle-gap detector.
// Optional watermark output wm_o is enabled by defining UART_RX_CTRL_WATERMARK_EN.
module uart_rx_ctrl #(
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned IdleTicks = 1000,
  parameter int unsigned Watermark = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_valid_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(FifoDepth):0]   level_o,
  output logic                         overrun_o,
  input  logic                         overrun_clr_i,
  output logic                         idle_o
`ifdef UART_RX_CTRL_WATERMARK_EN
  ,
  output logic                         wm_o
`endif
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(IdleTicks);

  localparam logic [LW-1:0] DepthLvl = LW'(FifoDepth);
  localparam logic [CW-1:0] CntLast  = CW'(IdleTicks - 1);

  localparam logic [0:0] StDisarmed = 1'b0;
  localparam logic [0:0] StCounting = 1'b1;

  logic [7:0]    r_mem [FifoDepth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_d;
  logic          r_overrun;
  logic [0:0]    r_state;
  logic [0:0]    w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_accept;
  logic w_drop;
  logic w_idle;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == DepthLvl);
  assign w_push   = rx_valid_i & enable_i;
  assign w_pop    = ~w_empty & ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  always_comb begin
    w_level_d = r_level;
    if (w_accept && !w_pop) begin
      w_level_d = r_level + LW'(1);
    end else if (!w_accept && w_pop) begin
      w_level_d = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_d;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idle    = 1'b0;
    if (!enable_i) begin
      w_state_d = StDisarmed;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StDisarmed: begin
          w_cnt_d = '0;
          if (w_accept) begin
            w_state_d = StCounting;
          end
        end
        StCounting: begin
          if (w_accept) begin
            w_cnt_d = '0;
          end else if (r_cnt == CntLast) begin
            w_idle    = 1'b1;
            w_state_d = StDisarmed;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_d = StDisarmed;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StDisarmed;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

`ifdef UART_RX_CTRL_WATERMARK_EN
  logic r_wm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wm <= 1'b0;
    end else begin
      r_wm <= (w_level_d >= LW'(Watermark));
    end
  end

  assign wm_o = r_wm;
`endif

  // Head is masked to zero when empty so data_o is defined out of reset.
  assign data_o    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign valid_o   = ~w_empty;
  assign level_o   = r_level;
  assign overrun_o = r_overrun;
  assign idle_o    = w_idle;

endmodule
